// File: rtl/spec_check_pkg.sv
// Shared types for the speculation checker: fetch prediction, queue entry,
// resolution outcome and the mispredict compare.
package tcore_param;

    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } predict_info_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } spec_entry_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_HIT,
        RES_MISS
    } resolve_e;

    // The predicted target only matters when the branch was actually taken.
    function automatic logic is_mispredict(spec_entry_t head, logic [31:0] ex_pc,
                                           logic ex_taken, logic [31:0] ex_target);
        return (head.pc != ex_pc) || (head.pred_taken != ex_taken) ||
               (ex_taken && (head.pred_pc != ex_target));
    endfunction

endpackage

// File: rtl/spec_check_if.sv
// Link between the checker (master) and its in-flight prediction queue (slave).
interface spec_check_if;
    import tcore_param::*;

    logic        push;
    logic        pop;
    logic        flush;
    logic        stall;
    spec_entry_t wdata;
    spec_entry_t rdata;
    logic        full;
    logic        empty;
    logic        overflow;

    modport master (
        output push, pop, flush, stall, wdata,
        input  rdata, full, empty, overflow
    );

    modport slave (
        input  push, pop, flush, stall, wdata,
        output rdata, full, empty, overflow
    );

endinterface

// File: rtl/spec_check_queue.sv
// Circular FIFO of outstanding predictions; pointers carry one extra wrap bit.
module spec_queue
    import tcore_param::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    spec_check_if.slave  q
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [AW:0] ptr_t;

    spec_entry_t mem_q [DEPTH];
    spec_entry_t mem_d [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        full, empty;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        do_pop     = q.pop && !q.stall && !empty;
        // A pop frees the head slot in the same cycle, so a full queue still accepts.
        do_push    = q.push && !q.stall && (!full || do_pop);
        if (!q.stall) begin
            if (q.flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (do_push) begin
                    mem_d[wr_ptr_q[AW-1:0]] = q.wdata;
                    wr_ptr_d = wr_ptr_q + ptr_t'(1);
                end
                if (do_pop) begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
            end
            if (q.push && full && !do_pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign q.rdata    = mem_q[rd_ptr_q[AW-1:0]];
    assign q.full     = full;
    assign q.empty    = empty;
    assign q.overflow = overflow_q;

endmodule

// File: rtl/spec_check.sv
// Compares execute-stage branch resolutions against queued fetch predictions
// and produces registered redirect, training and statistics outputs.
module spec_check
    import tcore_param::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          push_i,
    input  logic [31:0]   push_pc_i,
    input  predict_info_t spec_i,
    input  logic          ex_valid_i,
    input  logic [31:0]   ex_pc_i,
    input  logic          ex_taken_i,
    input  logic [31:0]   ex_target_i,
    input  logic [31:0]   ex_next_i,
    output logic          spec_hit_o,
    output logic          redirect_o,
    output logic [31:0]   redirect_pc_o,
    output logic          upd_valid_o,
    output logic [31:0]   upd_pc_o,
    output logic          upd_taken_o,
    output logic [31:0]   upd_target_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o
);

    spec_check_if q_if ();

    spec_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .q      (q_if.slave)
    );

    spec_entry_t head;
    resolve_e    res;
    logic [31:0] actual_next;

    logic        spec_hit_q,    spec_hit_d;
    logic        redirect_q,    redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        upd_valid_q,   upd_valid_d;
    logic [31:0] upd_pc_q,      upd_pc_d;
    logic        upd_taken_q,   upd_taken_d;
    logic [31:0] upd_target_q,  upd_target_d;
    logic [31:0] hit_cnt_q,     hit_cnt_d;
    logic [31:0] miss_cnt_q,    miss_cnt_d;

    always_comb begin
        // With nothing queued, fetch is assumed to have fallen through.
        if (q_if.empty) begin
            head = '{pc: ex_pc_i, pred_taken: 1'b0, pred_pc: ex_next_i};
        end else begin
            head = q_if.rdata;
        end
        actual_next = ex_taken_i ? ex_target_i : ex_next_i;
        res = RES_NONE;
        if (ex_valid_i && !stall_i) begin
            res = is_mispredict(head, ex_pc_i, ex_taken_i, ex_target_i) ? RES_MISS : RES_HIT;
        end
    end

    always_comb begin
        spec_hit_d    = spec_hit_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        upd_valid_d   = upd_valid_q;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (!stall_i) begin
            spec_hit_d  = 1'b1;
            redirect_d  = 1'b0;
            upd_valid_d = 1'b0;
            if (res != RES_NONE) begin
                upd_valid_d  = 1'b1;
                upd_pc_d     = ex_pc_i;
                upd_taken_d  = ex_taken_i;
                upd_target_d = ex_target_i;
            end
            case (res)
                RES_HIT:  hit_cnt_d = hit_cnt_q + 32'd1;
                RES_MISS: begin
                    miss_cnt_d    = miss_cnt_q + 32'd1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = actual_next;
                    spec_hit_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_hit_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            spec_hit_q    <= spec_hit_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign q_if.push  = push_i;
    assign q_if.pop   = ex_valid_i;
    assign q_if.flush = (res == RES_MISS);
    assign q_if.stall = stall_i;
    assign q_if.wdata = '{pc: push_pc_i, pred_taken: spec_i.taken, pred_pc: spec_i.pc};

    assign spec_hit_o    = spec_hit_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign upd_valid_o   = upd_valid_q;
    assign upd_pc_o      = upd_pc_q;
    assign upd_taken_o   = upd_taken_q;
    assign upd_target_o  = upd_target_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign full_o        = q_if.full;
    assign empty_o       = q_if.empty;
    assign overflow_o    = q_if.overflow;

endmodule

// File: tb/tb_spec_check.sv
// Scoreboard bench for spec_check: directed resolutions queue their expected
// registered response; a monitor checks each unstalled edge.
module tb_spec_check;
    import tcore_param::*;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          stall_i, push_i, ex_valid_i, ex_taken_i;
    logic [31:0]   push_pc_i, ex_pc_i, ex_target_i, ex_next_i;
    predict_info_t spec_i;
    logic          spec_hit_o, redirect_o, upd_valid_o, upd_taken_o;
    logic          full_o, empty_o, overflow_o;
    logic [31:0]   redirect_pc_o, upd_pc_o, upd_target_o, hit_cnt_o, miss_cnt_o;

    always #5 clk_i = ~clk_i;

    spec_check #(.DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .push_i        (push_i),
        .push_pc_i     (push_pc_i),
        .spec_i        (spec_i),
        .ex_valid_i    (ex_valid_i),
        .ex_pc_i       (ex_pc_i),
        .ex_taken_i    (ex_taken_i),
        .ex_target_i   (ex_target_i),
        .ex_next_i     (ex_next_i),
        .spec_hit_o    (spec_hit_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .upd_valid_o   (upd_valid_o),
        .upd_pc_o      (upd_pc_o),
        .upd_taken_o   (upd_taken_o),
        .upd_target_o  (upd_target_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        hit;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_res(input logic rd, input logic [31:0] rpc, input logic hit,
                              input logic [31:0] upc, input logic utk, input logic [31:0] utgt,
                              input logic [31:0] hc, input logic [31:0] mc);
        exp_t e;
        e.redirect = rd; e.rpc = rpc; e.hit = hit; e.upc = upc;
        e.utk = utk; e.utgt = utgt; e.hc = hc; e.mc = mc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic p, input logic [31:0] ppc, input logic ptk,
                         input logic [31:0] ppred, input logic ev, input logic [31:0] epc,
                         input logic etk, input logic [31:0] etgt, input logic [31:0] enx);
        push_i = p; push_pc_i = ppc; spec_i.taken = ptk; spec_i.pc = ppred;
        ex_valid_i = ev; ex_pc_i = epc; ex_taken_i = etk; ex_target_i = etgt; ex_next_i = enx;
        @(negedge clk_i);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs reflect the most recent unstalled edge.
    logic mon_stall, mon_res, mon_rst;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            mon_stall = stall_i;
            mon_res   = ex_valid_i && !stall_i;
            mon_rst   = rst_ni;
            #1;
            if (mon_rst && rst_ni && !mon_stall) begin
                chk("upd_valid", {31'd0, upd_valid_o}, {31'd0, mon_res});
                if (upd_valid_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got resolve output want none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("redirect",     {31'd0, redirect_o},  {31'd0, e.redirect});
                        chk("redirect_pc",  redirect_pc_o,        e.rpc);
                        chk("spec_hit",     {31'd0, spec_hit_o},  {31'd0, e.hit});
                        chk("upd_pc",       upd_pc_o,             e.upc);
                        chk("upd_taken",    {31'd0, upd_taken_o}, {31'd0, e.utk});
                        chk("upd_target",   upd_target_o,         e.utgt);
                        chk("hit_cnt",      hit_cnt_o,            e.hc);
                        chk("miss_cnt",     miss_cnt_o,           e.mc);
                    end
                end else begin
                    chk("idle_redirect", {31'd0, redirect_o}, 32'd0);
                    chk("idle_spec_hit", {31'd0, spec_hit_o}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0;
        push_i = 0; push_pc_i = 0; spec_i = '0;
        ex_valid_i = 0; ex_pc_i = 0; ex_taken_i = 0; ex_target_i = 0; ex_next_i = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_empty",    {31'd0, empty_o},    32'd1);
        chk("rst_full",     {31'd0, full_o},     32'd0);
        chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
        chk("rst_spec_hit", {31'd0, spec_hit_o}, 32'd1);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_rpc",      redirect_pc_o,       32'd0);
        chk("rst_hits",     hit_cnt_o,           32'd0);
        rst_ni = 1'b1;
        idle(1);

        // Correct taken prediction.
        drive(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0);
        expect_res(0, 32'h0, 1, 32'h100, 1, 32'h200, 1, 0);
        drive(0, 0, 0, 0, 1, 32'h100, 1, 32'h200, 32'h104);
        idle(1);

        // Predicted not-taken, actually taken.
        drive(1, 32'h104, 0, 32'h108, 0, 0, 0, 0, 0);
        expect_res(1, 32'h300, 0, 32'h104, 1, 32'h300, 1, 1);
        drive(0, 0, 0, 0, 1, 32'h104, 1, 32'h300, 32'h108);
        chk("miss_empty", {31'd0, empty_o}, 32'd1);
        idle(1);

        // Fill, overflow, then push+pop while full.
        drive(1, 32'h10, 0, 32'h14, 0, 0, 0, 0, 0);
        drive(1, 32'h14, 0, 32'h18, 0, 0, 0, 0, 0);
        drive(1, 32'h18, 0, 32'h1c, 0, 0, 0, 0, 0);
        drive(1, 32'h1c, 0, 32'h20, 0, 0, 0, 0, 0);
        chk("full_set",  {31'd0, full_o},     32'd1);
        chk("ovf_clear", {31'd0, overflow_o}, 32'd0);
        drive(1, 32'hdead, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("ovf_set",   {31'd0, overflow_o}, 32'd1);
        expect_res(0, 32'h300, 1, 32'h10, 0, 32'h99, 2, 1);
        drive(1, 32'h20, 0, 32'h24, 1, 32'h10, 0, 32'h99, 32'h14);
        chk("full_stays", {31'd0, full_o}, 32'd1);
        expect_res(0, 32'h300, 1, 32'h14, 0, 32'h0, 3, 1);
        drive(0, 0, 0, 0, 1, 32'h14, 0, 32'h0, 32'h18);
        expect_res(0, 32'h300, 1, 32'h18, 0, 32'h0, 4, 1);
        drive(0, 0, 0, 0, 1, 32'h18, 0, 32'h0, 32'h1c);
        expect_res(0, 32'h300, 1, 32'h1c, 0, 32'h0, 5, 1);
        drive(0, 0, 0, 0, 1, 32'h1c, 0, 32'h0, 32'h20);
        expect_res(0, 32'h300, 1, 32'h20, 0, 32'h0, 6, 1);
        drive(0, 0, 0, 0, 1, 32'h20, 0, 32'h0, 32'h24);
        chk("drain_empty", {31'd0, empty_o}, 32'd1);
        chk("ovf_sticky",  {31'd0, overflow_o}, 32'd1);
        idle(1);

        // Resolve with empty queue: implied not-taken prediction.
        expect_res(1, 32'h80, 0, 32'h40, 1, 32'h80, 6, 2);
        drive(0, 0, 0, 0, 1, 32'h40, 1, 32'h80, 32'h44);
        idle(1);

        // Mispredict with a concurrent push: the push is discarded.
        drive(1, 32'h50, 0, 32'h54, 0, 0, 0, 0, 0);
        expect_res(1, 32'h60, 0, 32'h50, 1, 32'h60, 6, 3);
        drive(1, 32'h58, 0, 32'h5c, 1, 32'h50, 1, 32'h60, 32'h54);
        chk("flush_push_empty", {31'd0, empty_o}, 32'd1);
        idle(1);

        // Stall across a resolve; release gives exactly one resolution.
        drive(1, 32'h70, 0, 32'h74, 0, 0, 0, 0, 0);
        stall_i = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h70, 0, 32'h0, 32'h74);
        drive(0, 0, 0, 0, 1, 32'h70, 0, 32'h0, 32'h74);
        drive(0, 0, 0, 0, 1, 32'h70, 0, 32'h0, 32'h74);
        chk("stall_empty", {31'd0, empty_o}, 32'd0);
        chk("stall_hits",  hit_cnt_o,        32'd6);
        chk("stall_upd",   {31'd0, upd_valid_o}, 32'd0);
        stall_i = 1'b0;
        expect_res(0, 32'h60, 1, 32'h70, 0, 32'h0, 7, 3);
        drive(0, 0, 0, 0, 1, 32'h70, 0, 32'h0, 32'h74);
        idle(1);
        chk("post_stall_hits",  hit_cnt_o,        32'd7);
        chk("post_stall_empty", {31'd0, empty_o}, 32'd1);

        // Asynchronous reset with entries in flight.
        drive(1, 32'h90, 0, 32'h94, 0, 0, 0, 0, 0);
        drive(1, 32'h94, 0, 32'h98, 0, 0, 0, 0, 0);
        push_i = 0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_empty",    {31'd0, empty_o},    32'd1);
        chk("arst_overflow", {31'd0, overflow_o}, 32'd0);
        chk("arst_hits",     hit_cnt_o,           32'd0);
        chk("arst_misses",   miss_cnt_o,          32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(3);
        chk("rel_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rel_empty",    {31'd0, empty_o},    32'd1);
        chk("sb_drained",   sb.size(),           32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
